hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Parametrised successor to the pipeline stall/flush unit for the 5-stage pipelined CPU. It generates the following controls:
- load-use stalls of configurable length, driven by a counter FSM;
- branch/jump flushes held for a configurable number of cycles;
- freezes while data memory is busy;
- EX-stage operand forwarding selects.

Saturating performance counters for stall and flush events are exposed for debug.

Parameters:
REG_AW, 5, register address width.
LOAD_LAT, 1, bubble cycles inserted per load-use hazard (1..7).
FLUSH_CYC, 1, cycles flush_if_id/flush_id_ex stay asserted after a taken redirect (1..3).
NPC_W, 3, width of npc_op; any nonzero value means redirect taken.
CNT_W, 16, performance counter width.

Ports:
clk  in  1  clock, rising edge.
rstn  in  1  asynchronous active-low reset.
id_rs1  in  REG_AW  rs1 of instruction in ID.
id_rs2  in  REG_AW  rs2 of instruction in ID.
id_use_rs1  in  1  ID instruction reads rs1.
id_use_rs2  in  1  ID instruction reads rs2.
ex_rd  in  REG_AW  rd in ID/EX.
ex_memread  in  1  ID/EX instruction is a load.
ex_regwrite  in  1  ID/EX writes rd.
mem_rd  in  REG_AW  rd in EX/MEM.
mem_regwrite  in  1  EX/MEM writes rd.
mem_memread  in  1  EX/MEM is a load.
wb_rd  in  REG_AW  rd in MEM/WB.
wb_regwrite  in  1  MEM/WB writes rd.
npc_op  in  NPC_W  next-PC select from control; nonzero means redirect.
mem_busy  in  1  data memory not ready; pipeline must freeze.
stall_pc  out  1  hold PC.
stall_if_id  out  1  hold IF/ID register.
bubble_id_ex  out  1  insert NOP into ID/EX.
freeze_all  out  1  hold every pipeline register (memory wait).
flush_if_id  out  1  squash IF/ID.
flush_id_ex  out  1  squash ID/EX.
fwd_a  out  2  EX operand A source: 00 regfile, 10 EX/MEM, 01 MEM/WB.
fwd_b  out  2  EX operand B source, same encoding.
state_o  out  2  current FSM state (debug).
stall_cnt  out  CNT_W  cycles with stall_pc=1 or freeze_all=1.
flush_cnt  out  CNT_W  redirect events accepted.

Behaviour:
- Clock/reset: one clock, clk. Reset rstn is asynchronous, active-low.
- Reset values:
  - state = IDLE; all counters 0.
  - All stall/flush/freeze outputs 0; fwd_a = fwd_b = 00.
  - Combinational outputs are forced 0 while rstn=0.

- Hazard terms:
  - hit1 = id_use_rs1 & ex_rd==id_rs1 & ex_rd!=0; hit2 likewise for rs2.
  - luse = ex_memread & (hit1 | hit2).
  - redir = npc_op != 0.

- Forwarding (combinational, all states):
  - fwd_a = 10 if mem_regwrite & !mem_memread & mem_rd!=0 & mem_rd==id_rs1 (as latched into EX).
  - Else 01 if wb_regwrite & wb_rd!=0 & wb_rd==rs1.
  - Else 00.
  - fwd_b is computed the same way on rs2.
  - EX/MEM takes priority over MEM/WB.

- FSM states: IDLE=00, LSTALL=01, FLUSH=10, MWAIT=11. Priority within a cycle: mem_busy > redir > luse.

- IDLE:
  - mem_busy: freeze_all=1 that cycle; go to MWAIT.
  - Else redir:
    - flush_if_id = flush_id_ex = 1 that cycle; flush_cnt += 1.
    - If FLUSH_CYC > 1, go to FLUSH with fcnt = FLUSH_CYC-1.
    - Any coincident luse is ignored, because the ID instruction is wrong-path.
  - Else luse:
    - stall_pc = stall_if_id = bubble_id_ex = 1 that cycle.
    - If LOAD_LAT > 1, go to LSTALL with scnt = LOAD_LAT-1.

- LSTALL:
  - Stall outputs stay 1; scnt decrements each cycle; return to IDLE after the cycle where scnt==1.
  - A redir in LSTALL aborts the stall: flush that cycle, then go to FLUSH or IDLE as from IDLE.
  - mem_busy in LSTALL goes to MWAIT; scnt is kept and resumed afterwards.

- FLUSH:
  - Flush outputs stay 1; fcnt decrements; go to IDLE after fcnt==1.
  - A new redir reloads fcnt = FLUSH_CYC-1 and increments flush_cnt.
  - luse is ignored.

- MWAIT:
  - freeze_all = stall_pc = stall_if_id = 1; no bubbles, no flushes.
  - When mem_busy falls, return next cycle to the saved state (IDLE or LSTALL with preserved scnt).
  - A redir arriving during MWAIT is held off: npc_op is required stable until the freeze ends.

- Counters:
  - stall_cnt increments on every cycle where stall_pc or freeze_all = 1.
  - Both counters saturate at all-ones and never wrap.

- Reset mid-stall or mid-flush: immediately returns to IDLE and all outputs go to 0.

Test Plan:
1. Load-use, LOAD_LAT=2: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> stall_pc/bubble_id_ex high for exactly 2 cycles, state 00->01->00; stall_cnt=2.
2. Load to x0: ex_memread=1, ex_rd=0, id_rs2=0 -> no stall, fwd_b=00.
3. Forwarding priority: mem_rd=7 (regwrite, not load) and wb_rd=7 (regwrite), id_rs1=7 -> fwd_a=10. Drop mem_regwrite -> fwd_a=01.
4. Redirect plus load-use in the same cycle, FLUSH_CYC=2: npc_op=3'b001 with luse=1 -> flush high for 2 cycles, no stall; flush_cnt=1.
5. Memory wait during LSTALL (LOAD_LAT=3): mem_busy=1 for 4 cycles after the first stall cycle -> freeze_all high 4 cycles, then 2 remaining LSTALL cycles; stall_cnt=7.
6. Async reset: drop rstn mid-FLUSH between clock edges -> all outputs 0 immediately, state_o=00, counters 0. Saturation: preload via long stall with CNT_W=4 -> stall_cnt holds at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// hazard_ctrl : pipeline stall/flush/freeze sequencer with EX forwarding
//               selects and saturating debug event counters.
// Revision    : 1.0
// ============================================================================
module hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_CYC = 1,
    parameter int NPC_W     = 3,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic              mem_memread,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic [NPC_W-1:0]  npc_op,
    input  logic              mem_busy,
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              bubble_id_ex,
    output logic              freeze_all,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LSTALL = 2'b01,
        FLUSH  = 2'b10,
        MWAIT  = 2'b11
    } state_t;

    localparam logic [2:0]       LAT_RELOAD = 3'(LOAD_LAT - 1);
    localparam logic [2:0]       FL_RELOAD  = 3'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t            state_q, state_d, ret_q, ret_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;

    logic hit1, hit2, luse, redir;
    logic stall, flush, freeze, flush_acc;

    // ex_regwrite is implied by ex_memread for a load; the hazard only needs the load flag.
    logic unused_ok;
    assign unused_ok = ex_regwrite;

    always_comb begin
        hit1  = id_use_rs1 && (ex_rd == id_rs1) && (ex_rd != '0);
        hit2  = id_use_rs2 && (ex_rd == id_rs2) && (ex_rd != '0);
        luse  = ex_memread && (hit1 || hit2);
        redir = (npc_op != '0);
    end

    // Operand source for the instruction currently in EX; EX/MEM beats MEM/WB.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (mem_regwrite && !mem_memread && (mem_rd != '0) && (mem_rd == rs))
            return 2'b10;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        cnt_d     = cnt_q;
        stall     = 1'b0;
        flush     = 1'b0;
        freeze    = 1'b0;
        flush_acc = 1'b0;
        if (rstn) begin
            if (state_q == MWAIT) begin
                // npc_op is held stable by the source, so redirects wait here.
                if (mem_busy) freeze = 1'b1;
                else          state_d = ret_q;
            end else if (mem_busy) begin
                freeze  = 1'b1;
                ret_d   = state_q;
                state_d = MWAIT;
            end else if (redir) begin
                flush     = 1'b1;
                flush_acc = 1'b1;
                if (FLUSH_CYC > 1) begin
                    state_d = FLUSH;
                    cnt_d   = FL_RELOAD;
                end else begin
                    state_d = IDLE;
                end
            end else if (state_q == FLUSH) begin
                flush = 1'b1;
                if (cnt_q == 3'd1) state_d = IDLE;
                else               cnt_d   = cnt_q - 3'd1;
            end else if (state_q == LSTALL) begin
                stall = 1'b1;
                if (cnt_q == 3'd1) state_d = IDLE;
                else               cnt_d   = cnt_q - 3'd1;
            end else if (luse) begin
                stall = 1'b1;
                if (LOAD_LAT > 1) begin
                    state_d = LSTALL;
                    cnt_d   = LAT_RELOAD;
                end
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        ex_rs1_d    = ex_rs1_q;
        ex_rs2_d    = ex_rs2_q;
        if ((stall || freeze) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (flush_acc && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        // Track the register numbers that ID/EX will hold; a NOP reads nothing.
        if (!freeze) begin
            if (stall || flush) begin
                ex_rs1_d = '0;
                ex_rs2_d = '0;
            end else begin
                ex_rs1_d = id_rs1;
                ex_rs2_d = id_rs2;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            ret_q       <= IDLE;
            cnt_q       <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
        end
    end

    assign stall_pc     = stall || freeze;
    assign stall_if_id  = stall || freeze;
    assign bubble_id_ex = stall;
    assign freeze_all   = freeze;
    assign flush_if_id  = flush;
    assign flush_id_ex  = flush;
    assign fwd_a        = rstn ? fwd_sel(ex_rs1_q) : 2'b00;
    assign fwd_b        = rstn ? fwd_sel(ex_rs2_q) : 2'b00;
    assign state_o      = state_q;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule
`default_nettype wire
